// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default RX FIFO depth and the status-bit layout
// that the register block uses to pack the FIFO flags.
package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int UART_RX_FIFO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    STAT_EMPTY   = 2'd0,
    STAT_FULL    = 2'd1,
    STAT_OVERRUN = 2'd2,
    STAT_IRQ     = 2'd3
  } uart_stat_bit_e;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the RX FIFO: synchronous write, registered read, no reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int AW = UART_RX_FIFO_DEPTH_LOG2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  uart_byte_t      wdata,
  input  logic [AW-1:0]   raddr,
  output uart_byte_t      rdata
);

  uart_byte_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO with fill level and sticky overrun.
// Optional level-threshold interrupt enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  flush,
  output logic                  overrun,
  input  logic                  clr_overrun
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  input  logic [DEPTH_LOG2:0]   irq_thresh,
  output logic                  irq
`endif
);

  localparam int AW = DEPTH_LOG2;
  typedef logic [AW:0] ptr_t;

  ptr_t       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic       do_push, do_pop, drop;
  logic       byp_sel;
  uart_byte_t byp_data, ram_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = rd_en && !empty && !flush;
  assign do_push = rx_valid && (!full || do_pop) && !flush;
  assign drop    = rx_valid && full && !rd_en && !flush;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (do_push) wr_ptr_nxt = wr_ptr + 1'b1;
      if (do_pop)  rd_ptr_nxt = rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clr_overrun)   overrun <= 1'b0;
  end

  // The RAM is read at the next head address; when that same slot is being written
  // this cycle the RAM returns stale data, so the incoming byte is forwarded instead.
  uart_fifo_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr_nxt[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_sel  <= 1'b1;
      byp_data <= '0;
    end else if (flush) begin
      byp_sel  <= 1'b1;
      byp_data <= '0;
    end else begin
      byp_sel  <= do_push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      byp_data <= rx_data;
    end
  end

  assign rd_data = byp_sel ? byp_data : ram_q;

`ifdef UART_RX_FIFO_IRQ_EN
  ptr_t level_nxt;
  assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (level_nxt >= irq_thresh) && (irq_thresh != '0);
  end
`endif

endmodule
